// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: out = (in1 - in2) mod 2^WIDTH, bout = borrow-out.
// Processes one bit per clock LSB-first; start/busy/done handshake for a controlling FSM.
module serial_subtractor #(
    parameter int WIDTH = 4,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             bout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] out_reg;
    logic [CW-1:0]    count_reg;
    logic             borrow_reg;
    logic             bout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             d_next;
    logic             borrow_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // One full-subtractor slice; the result fills from the top so bit 0 lands in place last.
    always_comb begin
        d_next      = a_reg[0] ^ b_reg[0] ^ borrow_reg;
        borrow_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow_reg);
        res_next    = {d_next, res_reg[WIDTH-1:1]};
        last_bit    = (count_reg == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res_reg    <= '0;
            out_reg    <= '0;
            count_reg  <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg      <= in1;
                        b_reg      <= in2;
                        res_reg    <= '0;
                        borrow_reg <= 1'b0;
                        count_reg  <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= SHIFT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    a_reg      <= a_reg >> 1;
                    b_reg      <= b_reg >> 1;
                    borrow_reg <= borrow_next;
                    res_reg    <= res_next;
                    count_reg  <= count_reg + CW'(1);
                    if (last_bit) begin
                        out_reg   <= res_next;
                        bout_reg  <= borrow_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign out  = out_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4: handshake timing, borrow/wrap,
// ignored and back-to-back starts, mid-operation reset and an exhaustive adder round-trip.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             bout;

    int n_assert = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(WIDTH), .CW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse and wait (bounded) for done; checks the WIDTH-cycle latency.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int k;
        in1   = a;
        in2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        chk("op_done_seen", {31'd0, done}, 32'd1);
        chk("op_latency", k, WIDTH);
        $display("op in1=%0d in2=%0d -> out=%0d bout=%0d", a, b, out, bout);
    endtask

    initial begin
        logic [4:0] sum;
        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_out",  {28'd0, out},  32'd0);
        chk("reset_bout", {31'd0, bout}, 32'd0);

        // Basic 9 - 3, with operand changes after capture that must be ignored
        in1 = 4'd9; in2 = 4'd3; start = 1'b1;
        tick();
        start = 1'b0; in1 = 4'd0; in2 = 4'd15;
        for (int c = 1; c <= 4; c++) begin
            chk("basic_busy", {31'd0, busy}, 32'd1);
            chk("basic_nodone", {31'd0, done}, 32'd0);
            tick();
        end
        chk("basic_done", {31'd0, done}, 32'd1);
        chk("basic_busy_low", {31'd0, busy}, 32'd0);
        chk("basic_out", {28'd0, out}, 32'd6);
        chk("basic_bout", {31'd0, bout}, 32'd0);
        $display("basic 9-3 -> out=%0d bout=%0d", out, bout);
        tick();
        chk("basic_done_pulse", {31'd0, done}, 32'd0);
        tick();
        chk("basic_out_hold", {28'd0, out}, 32'd6);
        chk("basic_bout_hold", {31'd0, bout}, 32'd0);

        // Borrow, wrap-around, equal operands
        do_op(4'd3, 4'd9);
        chk("borrow_out", {28'd0, out}, 32'hA);
        chk("borrow_bout", {31'd0, bout}, 32'd1);
        do_op(4'd0, 4'd1);
        chk("wrap_out", {28'd0, out}, 32'hF);
        chk("wrap_bout", {31'd0, bout}, 32'd1);
        do_op(4'd7, 4'd7);
        chk("equal_out", {28'd0, out}, 32'd0);
        chk("equal_bout", {31'd0, bout}, 32'd0);
        tick();

        // Start during SHIFT is ignored
        in1 = 4'd5; in2 = 4'd2; start = 1'b1;
        tick();                                  // cycle 1
        start = 1'b0;
        tick();                                  // cycle 2
        in1 = 4'd1; in2 = 4'd8; start = 1'b1;
        tick();                                  // cycle 3
        start = 1'b0;
        tick();                                  // cycle 4
        chk("ign_nodone_c4", {31'd0, done}, 32'd0);
        tick();                                  // cycle 5
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_out", {28'd0, out}, 32'd3);
        chk("ign_bout", {31'd0, bout}, 32'd0);
        $display("ignored-start 5-2 -> out=%0d bout=%0d", out, bout);
        begin
            int extra_done;
            extra_done = 0;
            for (int c = 6; c <= 14; c++) begin
                tick();
                if (done) extra_done++;
            end
            chk("ign_no_second_done", extra_done, 0);
            chk("ign_idle_busy", {31'd0, busy}, 32'd0);
        end

        // Back-to-back with start held high
        in1 = 4'd12; in2 = 4'd4; start = 1'b1;
        for (int c = 1; c <= 5; c++) tick();     // cycle 5
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_out1", {28'd0, out}, 32'd8);
        chk("b2b_bout1", {31'd0, bout}, 32'd0);
        $display("b2b #1 12-4 -> out=%0d bout=%0d", out, bout);
        in1 = 4'd4; in2 = 4'd12;
        tick();                                  // cycle 6
        chk("b2b_busy_again", {31'd0, busy}, 32'd1);
        for (int c = 6; c <= 9; c++) begin
            chk("b2b_nodone_mid", {31'd0, done}, 32'd0);
            chk("b2b_out_hold", {28'd0, out}, 32'd8);
            if (c < 9) tick();
        end
        tick();                                  // cycle 10
        start = 1'b0;
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_out2", {28'd0, out}, 32'd8);
        chk("b2b_bout2", {31'd0, bout}, 32'd1);
        $display("b2b #2 4-12 -> out=%0d bout=%0d", out, bout);
        tick();
        tick();

        // Reset mid-operation (out/bout currently 8/1 so clearing is visible)
        in1 = 4'd15; in2 = 4'd1; start = 1'b1;
        tick();                                  // cycle 1
        start = 1'b0;
        tick();                                  // cycle 2
        tick();                                  // cycle 3
        rst = 1'b1;
        tick();                                  // cycle 4
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", {28'd0, out}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        begin
            int stray_done;
            stray_done = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (done || busy) stray_done++;
            end
            chk("rst_abandoned", stray_done, 0);
        end
        $display("reset mid-op -> busy=%0d done=%0d out=%0d bout=%0d", busy, done, out, bout);
        do_op(4'd15, 4'd1);
        chk("rst_fresh_out", {28'd0, out}, 32'd14);
        chk("rst_fresh_bout", {31'd0, bout}, 32'd0);

        // Exhaustive round-trip through the 4-bit adder: in2 + out == {bout, in1}
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(WIDTH'(a), WIDTH'(b));
                sum = {1'b0, WIDTH'(b)} + {1'b0, out};
                chk("roundtrip", {27'd0, sum}, {27'd0, bout, WIDTH'(a)});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
